// File: rtl/euler1_pkg.sv
// Shared widths, limits and the FSM state encoding for the Euler-1 readout block.
package euler1_pkg;

  localparam int SLICE_W        = 6;
  localparam int NUM_SLICES     = 3;
  localparam int RESULT_W       = SLICE_W * NUM_SLICES;
  localparam int BCD_DIGITS     = 6;
  localparam int TIMEOUT_CYCLES = 1023;

  // IDLE is zero so that an asynchronous clear lands in it.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    READ = 3'd2,
    CONV = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/euler1_readout_if.sv
// Bus between the readout block and its environment: the request pulse, the
// core's sliced result port, and the collected binary/BCD results.
//
// Handshake: start is a single-cycle request that is taken on any rising edge.
// core_valid is a level flag from the core; a slice is accepted on every rising
// edge where the readout is in WAIT/READ and core_valid is 1. There is no ready
// back-pressure: core_sel tells the core which slice to present, and
// core_result must follow core_sel combinationally within the same cycle.
interface euler1_readout_if #(
  parameter int SLICE_W    = euler1_pkg::SLICE_W,
  parameter int RESULT_W   = euler1_pkg::RESULT_W,
  parameter int BCD_DIGITS = euler1_pkg::BCD_DIGITS
);

  logic                    start;
  logic                    core_valid;
  logic [SLICE_W-1:0]      core_result;
  logic [1:0]              core_sel;
  logic [RESULT_W-1:0]     result;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    busy;
  logic                    done;
  logic                    timeout;
  euler1_pkg::state_t      dbg_state;

  // Environment side: requests collections and models the core.
  modport master (
    output start, core_valid, core_result,
    input  core_sel, result, bcd, busy, done, timeout, dbg_state
  );

  // Readout side.
  modport slave (
    input  start, core_valid, core_result,
    output core_sel, result, bcd, busy, done, timeout, dbg_state
  );

endinterface

// File: rtl/euler1_readout_bin2bcd_seq.sv
// Iterative double-dabble converter: load, then one add-3/shift step per cycle
// for BIN_W cycles. done_o pulses during the last step and bcd_o carries the
// value the BCD register takes on that edge, so the caller can capture the
// final result on the same edge the conversion finishes.
module bin2bcd_seq
  import euler1_pkg::*;
#(
  parameter int BIN_W  = RESULT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                abort_i,
  input  logic [BIN_W-1:0]    bin_i,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    bin_q,    bin_d;
  logic [4*DIGITS-1:0] bcd_q,    bcd_d;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic                active_q, active_d;
  logic                last_step;

  // Add-3 correction, next-state and last-step detection for one shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    last_step = active_q && (cnt_q == CW'(BIN_W - 1));
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    if (abort_i) begin
      active_d = 1'b0;
    end else if (load_i) begin
      bin_d    = bin_i;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + CW'(1);
      if (last_step) begin
        active_d = 1'b0;
      end
    end
  end

  assign done_o = last_step && !abort_i;
  assign bcd_o  = bcd_d;

  // Converter working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/euler1_readout.sv
// Collects a sliced result from the Euler-1 core (one slice per cycle, selected
// by core_sel), reassembles it and converts it to packed BCD. A timeout guards
// the wait for the core; start restarts the collection from any state.
module euler1_readout #(
  parameter int SLICE_W        = euler1_pkg::SLICE_W,
  parameter int NUM_SLICES     = euler1_pkg::NUM_SLICES,
  parameter int BCD_DIGITS     = euler1_pkg::BCD_DIGITS,
  parameter int TIMEOUT_CYCLES = euler1_pkg::TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  euler1_readout_if.slave  bus
);

  import euler1_pkg::*;

  localparam int RESULT_W = SLICE_W * NUM_SLICES;
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state_q,    state_d;
  logic [1:0]              k_q,        k_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [RESULT_W-1:0]     result_q,   result_d;
  logic [4*BCD_DIGITS-1:0] bcd_q,      bcd_d;
  logic                    timeout_q,  timeout_d;
  logic                    conv_load;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;

  // Next-state logic; start overrides everything, including a valid core.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wait_cnt_d = wait_cnt_q;
    result_d   = result_q;
    bcd_d      = bcd_q;
    timeout_d  = timeout_q;
    conv_load  = 1'b0;
    if (bus.start) begin
      state_d    = WAIT;
      k_d        = 2'd0;
      wait_cnt_d = '0;
      result_d   = '0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
        end
        WAIT: begin
          if (bus.core_valid) begin
            result_d[SLICE_W-1:0] = bus.core_result;
            k_d                   = 2'd1;
            state_d               = READ;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            timeout_d  = 1'b1;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        READ: begin
          if (!bus.core_valid) begin
            // Core withdrew its result mid-read: drop the partial word.
            state_d    = WAIT;
            k_d        = 2'd0;
            wait_cnt_d = '0;
            result_d   = '0;
          end else begin
            for (int s = 1; s < NUM_SLICES; s++) begin
              if (k_q == 2'(s)) begin
                result_d[s*SLICE_W +: SLICE_W] = bus.core_result;
              end
            end
            if (k_q == 2'(NUM_SLICES - 1)) begin
              // Final slice goes straight into the converter's load value.
              k_d       = 2'd0;
              state_d   = CONV;
              conv_load = 1'b1;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        CONV: begin
          if (conv_done) begin
            bcd_d   = conv_bcd;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      wait_cnt_q <= '0;
      result_q   <= '0;
      bcd_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wait_cnt_q <= wait_cnt_d;
      result_q   <= result_d;
      bcd_q      <= bcd_d;
      timeout_q  <= timeout_d;
    end
  end

  bin2bcd_seq #(
    .BIN_W  (RESULT_W),
    .DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (conv_load),
    .abort_i (bus.start),
    .bin_i   (result_d),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // k is zero outside READ, so it doubles as the registered slice select.
  assign bus.core_sel  = k_q;
  assign bus.result    = result_q;
  assign bus.bcd       = bcd_q;
  assign bus.busy      = (state_q == WAIT) || (state_q == READ) || (state_q == CONV);
  assign bus.done      = (state_q == DONE);
  assign bus.timeout   = timeout_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_euler1_readout.sv
// Directed bench for euler1_readout with a combinational model of the core's
// sliced result port.
module tb_euler1_readout;

  import euler1_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] core_val;
  int          checks   = 0;
  int          failures = 0;

  euler1_readout_if bus ();

  euler1_readout dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Core model: presents the slice of core_val selected by core_sel.
  always_comb begin
    case (bus.core_sel)
      2'd0:    bus.core_result = core_val[5:0];
      2'd1:    bus.core_result = core_val[11:6];
      2'd2:    bus.core_result = core_val[17:12];
      default: bus.core_result = 6'h3f;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    // Reset
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.core_valid = 1'b0;
    core_val       = '0;
    ticks(3);
    chk("rst_state",   bus.dbg_state, IDLE);
    chk("rst_sel",     bus.core_sel,  0);
    chk("rst_result",  bus.result,    0);
    chk("rst_bcd",     bus.bcd,       0);
    chk("rst_busy",    bus.busy,      0);
    chk("rst_done",    bus.done,      0);
    chk("rst_timeout", bus.timeout,   0);
    rst = 1'b1;
    tick();
    chk("rel_state", bus.dbg_state, IDLE);

    // 233168 with core_valid rising 50 cycles after start
    core_val = 18'd233168;
    pulse_start();
    chk("a_wait",  bus.dbg_state, WAIT);
    chk("a_busy",  bus.busy,      1);
    ticks(49);
    chk("a_still_wait", bus.dbg_state, WAIT);
    chk("a_sel0",       bus.core_sel,  0);
    bus.core_valid = 1'b1;
    tick();
    chk("a_read",  bus.dbg_state, READ);
    chk("a_sel1",  bus.core_sel,  1);
    tick();
    chk("a_sel2",  bus.core_sel,  2);
    tick();
    chk("a_conv",  bus.dbg_state, CONV);
    chk("a_sel_c", bus.core_sel,  0);
    ticks(17);
    chk("a_done_early", bus.done, 0);
    chk("a_bcd_hold",   bus.bcd,  0);
    tick();
    chk("a_done",   bus.done,   1);
    chk("a_result", bus.result, 233168);
    chk("a_bcd",    bus.bcd,    24'h233168);
    chk("a_busy_d", bus.busy,   0);
    bus.core_valid = 1'b0;
    ticks(5);
    chk("a_done_hold", bus.done, 1);
    chk("a_bcd_stab",  bus.bcd,  24'h233168);

    // Value 0, core_valid already high on the first WAIT cycle
    core_val       = 18'd0;
    bus.core_valid = 1'b1;
    pulse_start();
    chk("b_wait",   bus.dbg_state, WAIT);
    chk("b_done_clr", bus.done,    0);
    tick();
    chk("b_read",   bus.dbg_state, READ);
    ticks(20);
    chk("b_done",   bus.done,   1);
    chk("b_result", bus.result, 0);
    chk("b_bcd",    bus.bcd,    0);

    // Maximum input
    core_val = 18'h3ffff;
    pulse_start();
    tick();
    ticks(20);
    chk("c_done",   bus.done,   1);
    chk("c_result", bus.result, 18'h3ffff);
    chk("c_bcd",    bus.bcd,    24'h262143);

    // Timeout: core_valid never asserted
    bus.core_valid = 1'b0;
    pulse_start();
    ticks(1022);
    chk("d_wait_1022", bus.dbg_state, WAIT);
    chk("d_to_early",  bus.timeout,   0);
    tick();
    chk("d_idle",  bus.dbg_state, IDLE);
    chk("d_to",    bus.timeout,   1);
    chk("d_done",  bus.done,      0);
    chk("d_busy",  bus.busy,      0);
    ticks(3);
    chk("d_sticky", bus.timeout, 1);
    pulse_start();
    chk("d_to_clr", bus.timeout, 0);

    // core_valid drops during the second READ cycle, then 999
    core_val       = 18'd999;
    bus.core_valid = 1'b1;
    tick();
    tick();
    chk("e_sel2", bus.core_sel, 2);
    bus.core_valid = 1'b0;
    tick();
    chk("e_back_wait", bus.dbg_state, WAIT);
    chk("e_sel0",      bus.core_sel,  0);
    chk("e_discard",   bus.result,    0);
    ticks(3);
    bus.core_valid = 1'b1;
    tick();
    ticks(19);
    chk("e_done_early", bus.done, 0);
    tick();
    chk("e_done",   bus.done,   1);
    chk("e_result", bus.result, 999);
    chk("e_bcd",    bus.bcd,    24'h000999);

    // start pulsed mid-CONV, new value 12345
    core_val = 18'd4321;
    pulse_start();
    tick();
    ticks(2);
    ticks(5);
    chk("f_conv", bus.dbg_state, CONV);
    core_val  = 18'd12345;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("f_wait",     bus.dbg_state, WAIT);
    chk("f_done0",    bus.done,      0);
    chk("f_bcd_hold", bus.bcd,       24'h000999);
    tick();
    ticks(19);
    chk("f_done_early", bus.done, 0);
    tick();
    chk("f_done",   bus.done,   1);
    chk("f_result", bus.result, 12345);
    chk("f_bcd",    bus.bcd,    24'h012345);

    // Asynchronous reset between edges mid-READ
    core_val = 18'd233168;
    pulse_start();
    tick();
    chk("g_read",    bus.dbg_state, READ);
    chk("g_partial", bus.result,    16);
    #2;
    rst = 1'b0;
    #1;
    chk("g_state",   bus.dbg_state, IDLE);
    chk("g_result",  bus.result,    0);
    chk("g_bcd",     bus.bcd,       0);
    chk("g_sel",     bus.core_sel,  0);
    chk("g_busy",    bus.busy,      0);
    chk("g_done",    bus.done,      0);
    chk("g_timeout", bus.timeout,   0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("g_idle_after", bus.dbg_state, IDLE);
    chk("g_result_after", bus.result,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/euler1_readout.md
EULER1_READOUT -- requirements
Module: euler1_readout

Interface
REQ-001 Parameter SLICE_W, default 6, width of one result slice from the Euler-1 core.
REQ-002 Parameter NUM_SLICES, default 3, slices per result; RESULT_W = SLICE_W*NUM_SLICES = 18.
REQ-003 Parameter BCD_DIGITS, default 6, decimal digits produced.
REQ-004 Parameter TIMEOUT_CYCLES, default 1023, maximum wait for core_valid.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-007 start  in  1  one-cycle pulse that begins a collection.
REQ-008 core_valid  in  1  core result-ready flag.
REQ-009 core_result  in  SLICE_W  slice selected by core_sel; combinational on core_sel.
REQ-010 core_sel  out  2  slice select to core (0 = bits 5:0, 1 = 11:6, 2 = 17:12).
REQ-011 result  out  RESULT_W  reassembled binary result.
REQ-012 bcd  out  4*BCD_DIGITS  packed BCD of result, most significant digit in top nibble.
REQ-013 busy  out  1  high in WAIT, READ, CONV.
REQ-014 done  out  1  high in DONE; result and bcd valid.
REQ-015 timeout  out  1  sticky; set when TIMEOUT_CYCLES elapse in WAIT.

Function
REQ-016 FSM states: IDLE, WAIT, READ, CONV, DONE.
REQ-017 IDLE: core_sel=0; start=1 -> WAIT, clear timeout, clear wait counter.
REQ-018 WAIT: core_sel=0; on an edge with core_valid=1, capture core_result into result[5:0], set slice index k=1 -> READ.
REQ-019 WAIT: wait counter increments each cycle; on reaching TIMEOUT_CYCLES with core_valid=0 -> IDLE with timeout=1.
REQ-020 READ: core_sel=k; each edge captures core_result into result[k*6+5:k*6]; k=1 -> k=2; k=2 -> CONV.
REQ-021 READ: core_valid sampled 0 on any edge -> discard partial result, return to WAIT (counter cleared).
REQ-022 CONV: double-dabble, one shift per cycle, exactly RESULT_W (18) cycles, then -> DONE.
REQ-023 Latency: done rises exactly 20 rising edges after the edge capturing slice 0.
REQ-024 DONE: result and bcd held stable; done=1 until start or reset.
REQ-025 start=1 in any state other than IDLE restarts: -> WAIT, done=0, timeout cleared, partial data discarded; start wins over simultaneous core_valid.
REQ-026 core_valid already high on the first WAIT cycle is captured on that cycle's edge.
REQ-027 bcd is updated only on entry to DONE; during CONV it holds its previous value.
REQ-028 Maximum input 262143 shall convert without overflow (bcd = 0x262143).

Reset
REQ-029 rst=0 asynchronously forces IDLE, core_sel=0, result=0, bcd=0, busy=0, done=0, timeout=0, k=0, counters=0.
REQ-030 Reset release is synchronous-safe: first state change only on a rising edge with rst=1.
REQ-031 Reset mid-READ or mid-CONV discards all partial data; no output glitch to nonzero after reset.

Structure
REQ-032 Package euler1_pkg holds SLICE_W, NUM_SLICES, RESULT_W, BCD_DIGITS, and the FSM state enum.
REQ-033 Sub-module bin2bcd_seq performs the iterative double-dabble (load, 18 shift-add-3 cycles, done pulse); euler1_readout instantiates it once.
REQ-034 No combinational path from core_result to any output; core_sel driven from a register.

Verification
REQ-035 Core model holding 233168 with core_valid rising 50 cycles after start -> result=233168, bcd=0x233168, done 20 edges after capture, core_sel sequence 0,1,2.
REQ-036 Core value 0 -> bcd=0x000000, done=1; core value 262143 -> bcd=0x262143.
REQ-037 core_valid never asserted -> timeout=1, state IDLE after 1023 WAIT cycles, done=0.
REQ-038 core_valid dropped during second READ cycle -> returns to WAIT; later valid with 999 -> bcd=0x000999.
REQ-039 start pulsed mid-CONV -> done=0, re-collect; new value 12345 -> bcd=0x012345.
REQ-040 rst=0 asserted between edges mid-READ -> all outputs 0 immediately, IDLE after release.
